// File: rtl/matmul_core.sv
// matmul_core: sequential n x n matrix multiplier, C = A x B, one MAC unit.
//
// A and B are loaded as row-major element streams (load_valid/load_ready,
// load_sel picks A=0 / B=1). start launches the multiply; busy is high while
// it runs, done is held from completion until the next accepted start. C is
// read combinationally through (rd_i, rd_j); out-of-range indices read 0.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   load_valid/sel/data, load_ready   element load stream
//   start, busy, done           multiply control / status
//   rd_i, rd_j, rd_value        combinational C read port
//
// Build option: define MATMUL_SAT_EN to form full-width products and
// saturate the accumulator at 2^DW-1 instead of wrapping.
module matmul_core #(
    parameter int unsigned n  = 8,
    parameter int unsigned DW = 32,
    parameter int unsigned IW = $clog2(n) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_valid,
    input  logic          load_sel,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic [IW-1:0] rd_i,
    input  logic [IW-1:0] rd_j,
    output logic [DW-1:0] rd_value
);

    localparam int unsigned   AW       = $clog2(n * n);
    localparam logic [AW-1:0] CNT_LAST = AW'(n * n - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(n - 1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_STORE, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          busy_q, done_q;

    logic [DW-1:0] mem_a [n*n];
    logic [DW-1:0] mem_b [n*n];
    logic [DW-1:0] mem_c [n*n];

    logic          load_fire;
    logic [DW-1:0] a_op, b_op, mac_next;

    function automatic logic [AW-1:0] idx(input logic [IW-1:0] r, input logic [IW-1:0] c);
        return AW'(32'(r) * n + 32'(c));
    endfunction

    assign load_ready = (state_q == S_IDLE) || (state_q == S_DONE);
    // Beats presented while reset is held are not written.
    assign load_fire  = load_valid && load_ready && rst_n;
    assign busy       = busy_q;
    assign done       = done_q;

    assign a_op = mem_a[idx(i_q, k_q)];
    assign b_op = mem_b[idx(k_q, j_q)];

`ifdef MATMUL_SAT_EN
    logic [2*DW-1:0] prod;
    logic [2*DW:0]   sum;
    // acc only grows, so once clamped it stays clamped for the element.
    always_comb begin
        prod     = (2*DW)'(a_op) * (2*DW)'(b_op);
        sum      = (2*DW+1)'(acc_q) + (2*DW+1)'(prod);
        mac_next = (|sum[2*DW:DW]) ? '1 : sum[DW-1:0];
    end
`else
    always_comb begin
        mac_next = acc_q + a_op * b_op;
    end
`endif

    always_comb begin
        state_d = state_q;
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;

        if (load_fire && !load_sel) begin
            a_cnt_d = (a_cnt_q == CNT_LAST) ? '0 : a_cnt_q + 1'b1;
        end
        if (load_fire && load_sel) begin
            b_cnt_d = (b_cnt_q == CNT_LAST) ? '0 : b_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_MAC;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            S_MAC: begin
                acc_d = mac_next;
                k_d   = k_q + 1'b1;
                if (k_q == IDX_LAST) begin
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                acc_d = '0;
                k_d   = '0;
                if (j_q == IDX_LAST) begin
                    j_d = '0;
                    i_d = i_q + 1'b1;
                    state_d = (i_q == IDX_LAST) ? S_DONE : S_MAC;
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = S_MAC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_cnt_q <= '0;
            b_cnt_q <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            busy_q  <= (state_d == S_MAC) || (state_d == S_STORE);
            done_q  <= (state_d == S_DONE);
        end
    end

    // Matrix storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (load_fire && !load_sel) begin
            mem_a[a_cnt_q] <= load_data;
        end
        if (load_fire && load_sel) begin
            mem_b[b_cnt_q] <= load_data;
        end
        if (state_q == S_STORE) begin
            mem_c[idx(i_q, j_q)] <= acc_q;
        end
    end

    assign rd_value = (32'(rd_i) < n && 32'(rd_j) < n) ? mem_c[idx(rd_i, rd_j)] : '0;

endmodule

// File: tb/tb_matmul_core.sv
// Self-checking bench for matmul_core (n=8, DW=32): a behavioural model of
// the load stream, run timing and C contents is checked every cycle, with
// directed literal checks for identity, constant, overflow, busy protection,
// mid-run reset and out-of-range reads, followed by randomized rounds.
module tb_matmul_core;

    localparam int N     = 8;
    localparam int DW    = 32;
    localparam int IW    = $clog2(N) + 1;
    localparam int TOTAL = N * N * (N + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_valid;
    logic          load_sel;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic          start;
    logic          busy;
    logic          done;
    logic [IW-1:0] rd_i;
    logic [IW-1:0] rd_j;
    logic [DW-1:0] rd_value;

    always #5 clk = ~clk;

    matmul_core #(.n(N), .DW(DW), .IW(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_sel   (load_sel),
        .load_data  (load_data),
        .load_ready (load_ready),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .rd_i       (rd_i),
        .rd_j       (rd_j),
        .rd_value   (rd_value)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] ma [N*N];
    logic [31:0] mb [N*N];
    logic [31:0] mc [N*N];
    int  a_cnt   = 0;
    int  b_cnt   = 0;
    int  cyc     = 0;
    bit  running = 0;
    bit  done_e  = 0;
    bit  chk_on  = 0;

    function automatic void compute_c();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                longint unsigned s = 0;
                for (int k = 0; k < N; k++) begin
                    longint unsigned p = longint'(ma[i*N+k]) * longint'(mb[k*N+j]);
`ifdef MATMUL_SAT_EN
                    s = s + p;
                    if (s > 64'h0000_0000_FFFF_FFFF) s = 64'h0000_0000_FFFF_FFFF;
`else
                    s = (s + (p & 64'hFFFF_FFFF)) & 64'hFFFF_FFFF;
`endif
                end
                mc[i*N+j] = s[31:0];
            end
        end
    endfunction

    function automatic logic [31:0] exp_rd(input logic [IW-1:0] ri, input logic [IW-1:0] rj);
        int r = int'(ri);
        int c = int'(rj);
        if (r < N && c < N) return mc[r*N+c];
        return 32'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running = 0;
            done_e  = 0;
            a_cnt   = 0;
            b_cnt   = 0;
            cyc     = 0;
        end else if (!running) begin
            if (load_valid) begin
                if (load_sel) begin
                    mb[b_cnt] = load_data;
                    b_cnt = (b_cnt + 1) % (N*N);
                end else begin
                    ma[a_cnt] = load_data;
                    a_cnt = (a_cnt + 1) % (N*N);
                end
            end
            if (start) begin
                running = 1;
                done_e  = 0;
                cyc     = 0;
            end
        end else begin
            cyc++;
            if (cyc == TOTAL) begin
                running = 0;
                done_e  = 1;
                compute_c();
            end
        end
    end

    // One compare process, sampling away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", 32'(busy), 32'(running));
            chk("done", 32'(done), 32'(done_e));
            chk("load_ready", 32'(load_ready), 32'(!running));
            if (done_e) chk("rd_value", rd_value, exp_rd(rd_i, rd_j));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_beat(input bit sel, input logic [31:0] d);
        load_valid = 1'b1;
        load_sel   = sel;
        load_data  = d;
        step();
        load_valid = 1'b0;
    endtask

    task automatic check_rd(input string name, input int i, input int j, input logic [31:0] exp);
        rd_i = IW'(i);
        rd_j = IW'(j);
        #1;
        chk(name, rd_value, exp);
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            rd_i = IW'($urandom_range(0, N + 1));
            rd_j = IW'($urandom_range(0, N + 1));
            step();
        end
    endtask

    // Starts a multiply and waits for done; returns the edge count at which
    // done was first seen. Optionally pokes start + junk beats mid-run, or
    // resets mid-run (then returns early).
    task automatic run(input int inject_at, input int reset_at, output int edges);
        start = 1'b1;
        step();
        start = 1'b0;
        load_valid = 1'b0;
        chk("busy_after_start", 32'(busy), 32'h1);
        edges = 0;
        while (!done && edges < TOTAL + 50) begin
            rd_i       = IW'($urandom_range(0, N + 1));
            rd_j       = IW'($urandom_range(0, N + 1));
            start      = (edges == inject_at);
            load_valid = (inject_at >= 0 && edges >= inject_at && edges < inject_at + 10);
            load_sel   = 1'b0;
            load_data  = 32'hDEAD;
            if (load_valid) chk("ready_while_busy", 32'(load_ready), 32'h0);
            if (edges == reset_at) begin
                start      = 1'b0;
                load_valid = 1'b0;
                rst_n      = 1'b0;
                #1;
                chk("rst_mid_busy", 32'(busy), 32'h0);
                chk("rst_mid_done", 32'(done), 32'h0);
                chk("rst_mid_ready", 32'(load_ready), 32'h1);
                step();
                rst_n = 1'b1;
                step();
                return;
            end
            step();
            edges++;
        end
        start      = 1'b0;
        load_valid = 1'b0;
        if (!done) chk("done_timeout", 32'(done), 32'h1);
    endtask

    function automatic logic [31:0] rand_elem();
        return ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        logic [31:0] ovf;
        for (int x = 0; x < N*N; x++) begin
            ma[x] = '0;
            mb[x] = '0;
            mc[x] = '0;
        end
        rst_n = 1'b0; load_valid = 1'b0; load_sel = 1'b0; load_data = '0;
        start = 1'b0; rd_i = '0; rd_j = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ready", 32'(load_ready), 32'h1);
        rst_n = 1'b1;
        step();

        // Identity
        for (int v = 0; v < N*N; v++) load_beat(1'b0, 32'(v + 1));
        for (int v = 0; v < N*N; v++) load_beat(1'b1, (v / N == v % N) ? 32'h1 : 32'h0);
        run(-1, -1, e);
        chk("identity_done_edge", 32'(e), 32'd576);
        check_rd("id_c00", 0, 0, 32'd1);
        check_rd("id_c35", 3, 5, 32'd30);
        check_rd("id_c70", 7, 0, 32'd57);
        check_rd("id_c77", 7, 7, 32'd64);
        check_rd("oor_read", 8, 0, 32'd0);
        idle(10);

        // Constant matrices
        for (int v = 0; v < N*N; v++) load_beat(1'b0, 32'd2);
        for (int v = 0; v < N*N; v++) load_beat(1'b1, 32'd3);
        run(-1, -1, e);
        chk("const_done_edge", 32'(e), 32'd576);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check_rd("const_c", i, j, 32'd48);
        idle(10);

        // Overflow
`ifdef MATMUL_SAT_EN
        ovf = 32'hFFFF_FFFF;
`else
        ovf = 32'h0;
`endif
        for (int v = 0; v < N*N; v++) load_beat(1'b0, 32'h8000_0000);
        for (int v = 0; v < N*N; v++) load_beat(1'b1, 32'd1);
        run(-1, -1, e);
        check_rd("ovf_c00", 0, 0, ovf);
        check_rd("ovf_c47", 4, 7, ovf);
        check_rd("ovf_c77", 7, 7, ovf);
        idle(10);

        // Busy protection
        for (int v = 0; v < N*N; v++) load_beat(1'b0, rand_elem());
        for (int v = 0; v < N*N; v++) load_beat(1'b1, rand_elem());
        run(100, -1, e);
        chk("busyprot_done_edge", 32'(e), 32'd576);
        idle(30);

        // Reset mid-run, then a fresh run on the retained matrices
        run(-1, 300, e);
        run(-1, -1, e);
        chk("post_reset_done_edge", 32'(e), 32'd576);
        idle(30);

        // Randomized rounds: partial/wrapping loads, gaps, start on a beat
        for (int r = 0; r < 3; r++) begin
            int beats = $urandom_range(30, 150);
            for (int b = 0; b < beats; b++) begin
                load_valid = ($urandom_range(0, 3) != 0);
                load_sel   = $urandom_range(0, 1) != 0;
                load_data  = rand_elem();
                step();
            end
            load_valid = 1'b1;
            load_sel   = $urandom_range(0, 1) != 0;
            load_data  = rand_elem();
            run(-1, -1, e);
            chk("rand_done_edge", 32'(e), 32'd576);
            idle(40);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
